// File: rtl/anti_theft_fsm_param.sv
// Car anti-theft controller: arm delay, door-triggered countdown, siren, auto re-arm.
// Owns its tick prescaler and countdown timer; adds status LED and fuel-pump interlock.
module anti_theft_fsm_param #(
    parameter int N_DOORS           = 2,
    parameter int TICK_DIV          = 27000000,
    parameter int TW                = 4,
    parameter int T_ARM_DELAY       = 6,
    parameter int T_DRIVER_DELAY    = 8,
    parameter int T_PASSENGER_DELAY = 15,
    parameter int T_ALARM_ON        = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_DOORS-1:0] doors,
    input  logic               ignition,
    input  logic               hidden_switch,
    input  logic               brake_pedal,
    output logic               siren,
    output logic               status_led,
    output logic               fuel_pump,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        ARMED       = 3'd0,
        TRIGGERED   = 3'd1,
        SOUND_ALARM = 3'd2,
        DISARMED    = 3'd3,
        WAIT_OPEN   = 3'd4,
        WAIT_CLOSE  = 3'd5,
        ARM_DELAY   = 3'd6
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    // A zero delay would never expire cleanly, so it is promoted to one tick.
    function automatic logic [TW-1:0] load_value(input int v);
        return (v <= 0) ? TW'(1) : TW'(v);
    endfunction

    localparam logic [TW-1:0] ARM_V = load_value(T_ARM_DELAY);
    localparam logic [TW-1:0] DRV_V = load_value(T_DRIVER_DELAY);
    localparam logic [TW-1:0] PAS_V = load_value(T_PASSENGER_DELAY);
    localparam logic [TW-1:0] ALM_V = load_value(T_ALARM_ON);

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   count;
    logic [PW-1:0]   prescaler;
    logic            loaded;
    logic            blink;
    logic            load;
    logic [TW-1:0]   load_val;
    logic            tick;
    logic            expired;
    logic            any_open;

    assign any_open = |doors;
    assign tick     = (prescaler == PRE_MAX);
    assign expired  = loaded && (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        if (ignition) begin
            state_next = DISARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (any_open) begin
                        state_next = TRIGGERED;
                        load       = 1'b1;
                        load_val   = doors[0] ? DRV_V : PAS_V;
                    end
                end
                TRIGGERED: begin
                    if (expired) state_next = SOUND_ALARM;
                end
                SOUND_ALARM: begin
                    // Timer stays idle while open; first closed cycle (re)loads it.
                    if (!any_open) begin
                        if (!loaded) begin
                            load     = 1'b1;
                            load_val = ALM_V;
                        end else if (expired) begin
                            state_next = ARMED;
                        end
                    end
                end
                DISARMED:  state_next = WAIT_OPEN;
                WAIT_OPEN: begin
                    if (doors[0]) state_next = WAIT_CLOSE;
                end
                WAIT_CLOSE: begin
                    if (!any_open) begin
                        state_next = ARM_DELAY;
                        load       = 1'b1;
                        load_val   = ARM_V;
                    end
                end
                ARM_DELAY: begin
                    if (any_open)     state_next = WAIT_CLOSE;
                    else if (expired) state_next = ARMED;
                end
                default:   state_next = ARMED;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            prescaler <= '0;
        end else if (load) begin
            count     <= load_val;
            prescaler <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick && count != '0) count <= count - 1'b1;
        end
    end

    // loaded marks a count that belongs to the current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            loaded <= 1'b0;
        end else if (load) begin
            loaded <= 1'b1;
        end else if (state_next != state) begin
            loaded <= 1'b0;
        end else if (state == SOUND_ALARM && any_open) begin
            loaded <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink <= 1'b0;
        end else if (state_next == ARMED && state != ARMED) begin
            blink <= 1'b0;
        end else if (state == ARMED && tick) begin
            blink <= ~blink;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || !ignition) begin
            fuel_pump <= 1'b0;
        end else if (hidden_switch && brake_pedal) begin
            fuel_pump <= 1'b1;
        end
    end

    always_comb begin
        siren     = (state == SOUND_ALARM);
        state_out = state;
        case (state)
            ARMED:                  status_led = blink;
            TRIGGERED, SOUND_ALARM: status_led = 1'b1;
            default:                status_led = 1'b0;
        endcase
    end

endmodule

// File: doc/anti_theft_fsm_param.md
Name: anti_theft_fsm_param

Overview:
- Parametrised car anti-theft controller: arm delay, door-triggered countdown, siren, auto re-arm.
- Generalises the single driver/passenger door pair to N_DOORS doors.
- Owns its timer and second-tick prescaler; all delays are parameters.
- Adds a status LED and a hidden-switch fuel-pump interlock. Inputs arrive already debounced and synchronised to clock.

Parameters:
- N_DOORS, 2, door count; bit 0 is the driver door, bits 1.. are passenger/hatch doors (minimum 2).
- TICK_DIV, 27000000, clock cycles per timer tick (one second).
- TW, 4, timer count width in ticks.
- T_ARM_DELAY, 6, ticks from all-doors-closed to ARMED.
- T_DRIVER_DELAY, 8, ticks of countdown when the driver door triggers.
- T_PASSENGER_DELAY, 15, ticks of countdown when only passenger doors trigger.
- T_ALARM_ON, 10, ticks the siren stays on after all doors close.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- doors  in  N_DOORS  1 = door open; bit 0 is the driver door.
- ignition  in  1  1 = key on.
- hidden_switch  in  1  concealed switch.
- brake_pedal  in  1  1 = pedal pressed.
- siren  out  1  alarm sounder.
- status_led  out  1  arming indicator.
- fuel_pump  out  1  fuel pump enable.
- state_out  out  3  current state encoding, for display/debug.

Behaviour:
- State encoding:
  - ARMED=0, TRIGGERED=1, SOUND_ALARM=2, DISARMED=3, WAIT_OPEN=4, WAIT_CLOSE=5, ARM_DELAY=6.
  - Code 7 is illegal; it recovers to ARMED on the next edge.
- Reset values: state=ARMED; siren=0; status_led=0; fuel_pump=0; timer count=0; prescaler=0; blink=0. Reset in any state, including mid-alarm, forces these values at the next edge.
- Priority: ignition=1 moves any state to DISARMED on the next edge and overrides every other condition.
- Transitions (ignition=0):
  - ARMED: any door open -> TRIGGERED. Load T_DRIVER_DELAY if doors[0]=1, else T_PASSENGER_DELAY. If the driver and a passenger door open in the same cycle, the driver delay is used.
  - TRIGGERED: further door activity is ignored, with no reload. On timer expiry -> SOUND_ALARM.
  - SOUND_ALARM: while any door is open, stay and keep the timer idle. On the first cycle with all doors closed, load T_ALARM_ON. If a door reopens, the timer returns to idle and reloads at the next close. On expiry with all doors closed -> ARMED.
  - DISARMED -> WAIT_OPEN.
  - WAIT_OPEN: doors[0]=1 -> WAIT_CLOSE. Passenger doors alone do not advance.
  - WAIT_CLOSE: all doors closed -> ARM_DELAY, load T_ARM_DELAY.
  - ARM_DELAY: any door open -> WAIT_CLOSE (timer abandoned). On expiry -> ARMED.
- Timer:
  - On a load edge: count <= V (V=0 is treated as 1) and prescaler <= 0.
  - Prescaler free-runs 0..TICK_DIV-1. A tick occurs on the cycle where prescaler=TICK_DIV-1; count decrements on a tick when count>0.
  - expired = (count==0) and the timer was loaded in the current state.
  - A load at edge E gives a state change at edge E + V*TICK_DIV + 1.
  - Counting saturates at 0 and never wraps.
- siren = 1 iff state=SOUND_ALARM.
- status_led:
  - ARMED: equals blink. blink is cleared on entry to ARMED and toggles on each tick.
  - TRIGGERED and SOUND_ALARM: constant 1.
  - All other states: 0.
- fuel_pump:
  - Registered. Cleared whenever ignition=0.
  - Set on the edge where ignition=1, hidden_switch=1 and brake_pedal=1.
  - Once set, holds while ignition=1, even if the switch or pedal is released.
  - Independent of the alarm state.

Test Plan:
Common bench parameters: N_DOORS=3, TICK_DIV=4, TW=4, T_ARM_DELAY=2, T_DRIVER_DELAY=3, T_PASSENGER_DELAY=5, T_ALARM_ON=2.
- Arm sequence: reset, ignition=1 then 0, doors=001 then 000 -> state 3,4,5,6. ARMED is reached exactly 9 cycles after the ARM_DELAY load edge. In ARMED, status_led toggles every 4 cycles.
- Driver trigger: in ARMED set doors=001 -> TRIGGERED; siren rises 13 cycles after the load. Repeat with doors=110 -> 21 cycles. Repeat with doors=011 -> 13 cycles (driver priority).
- Alarm hold and re-arm: in SOUND_ALARM hold doors=010 for 50 cycles -> siren stays 1. Close the door -> siren falls and ARMED is reached 9 cycles after close. Reopening mid-count restarts the full 9 cycles.
- Ignition override: ignition=1 in TRIGGERED, SOUND_ALARM and ARM_DELAY -> DISARMED next edge, siren=0, status_led=0.
- Fuel pump: ignition=1, brake=1, hidden=0 -> fuel_pump=0. Raise hidden -> 1 next edge. Release both -> stays 1. Ignition=0 -> 0 next edge.
- Reset mid-operation: assert reset during SOUND_ALARM and during ARM_DELAY -> next edge state_out=0, siren=0, status_led=0, fuel_pump=0, and no spurious expiry afterwards.
